// File: rtl/fp_pkg.sv
// fp_pkg: shared binary64 constants, zero-detect helper and the accumulator
// sequencer state encoding. Imported by fp_vec_accum.
package fp_pkg;

    localparam int          FP64_W    = 64;
    localparam logic [63:0] FP64_ZERO = 64'h0;
    localparam logic [63:0] FP64_ONE  = 64'h3FF0000000000000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } fp_acc_state_t;

    // True for +0 and -0: the sign bit is ignored.
    function automatic logic is_zero(input logic [63:0] v);
        return v[62:0] == 63'h0;
    endfunction

endpackage

// File: rtl/fp_vec_accum.sv
// fp_vec_accum: serial binary64 vector-sum sequencer feeding an external
// fp_adder. Elements arrive on in_* (framed by in_last); each element after
// the first is issued to the adder as (running sum, element) on add_*, and
// the adder result becomes the new running sum. One sum per vector is
// presented on out_* with the accepted element count.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_last   element stream
//   add_valid/add_a/add_b       one-cycle issue to fp_adder
//   add_finish/add_result       fp_adder completion
//   out_valid/out_ready/out_data/out_count  vector sum + element count
//
// Config macro: FP_ACC_ZERO_SKIP_EN -- when defined, +/-0 elements seen in
// FETCH are absorbed without an adder round-trip.
module fp_vec_accum
    import fp_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              add_valid,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic              add_finish,
    input  logic [DATA_W-1:0] add_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
);

    fp_acc_state_t     state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] add_a_q, add_a_d;
    logic [DATA_W-1:0] add_b_q, add_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              add_valid_q, add_valid_d;
    logic              out_valid_q, out_valid_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = in_valid & in_ready_q;
    // Count sticks at all-ones; summing continues regardless.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = in_last ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    cnt_d = cnt_inc;
`ifdef FP_ACC_ZERO_SKIP_EN
                    if (is_zero(in_data)) begin
                        // acc + (+/-0) == acc except -0 + +0; keeping acc
                        // as-is is the intended result here.
                        state_d = in_last ? DONE : FETCH;
                    end else begin
                        add_a_d = acc_q;
                        add_b_d = in_data;
                        last_d  = in_last;
                        state_d = ISSUE;
                    end
`else
                    add_a_d = acc_q;
                    add_b_d = in_data;
                    last_d  = in_last;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (add_finish) begin
                    acc_d   = add_result;
                    state_d = last_q ? DONE : FETCH;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they align with state_q.
        in_ready_d  = (state_d == IDLE) || (state_d == FETCH);
        add_valid_d = (state_d == ISSUE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= FP64_ZERO;
            add_a_q     <= FP64_ZERO;
            add_b_q     <= FP64_ZERO;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            add_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            add_valid_q <= add_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_valid = add_valid_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign out_valid = out_valid_q;
    // acc/cnt are frozen in DONE, so they serve directly as the held output.
    assign out_data  = acc_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_fp_vec_accum.sv
module tb_fp_vec_accum;

    localparam logic [63:0] F1   = 64'h3FF0000000000000;
    localparam logic [63:0] F2   = 64'h4000000000000000;
    localparam logic [63:0] F3   = 64'h4008000000000000;
    localparam logic [63:0] F6   = 64'h4018000000000000;
    localparam logic [63:0] FM35 = 64'hC00C000000000000;
    localparam logic [63:0] PZ   = 64'h0;
    localparam logic [63:0] NZ   = 64'h8000000000000000;
`ifdef FP_ACC_ZERO_SKIP_EN
    localparam int ZADDS = 1;
`else
    localparam int ZADDS = 3;
`endif

    logic        clk = 0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_data;
    logic        add_valid, add_finish;
    logic [63:0] add_a, add_b, add_result;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [15:0] out_count;

    int total = 0;
    int bad   = 0;
    int n_add = 0;

    // adder model: result appears ~8 cycles after the issue pulse
    logic        mdl_fin = 0;
    logic [63:0] mdl_sum = 0;
    int          mdl_cnt = 0;
    logic        spur_fin;
    logic [63:0] spur_res;

    assign add_finish = mdl_fin | spur_fin;
    assign add_result = spur_fin ? spur_res : mdl_sum;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mdl_fin <= 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_fin <= 1'b1;
        end
        if (add_valid) begin
            mdl_cnt <= 8;
            mdl_sum <= $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));
            n_add   = n_add + 1;
        end
    end

    fp_vec_accum #(.DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_finish(add_finish), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at a negedge after the element is taken
    task automatic send(input logic [63:0] d, input logic l);
        int t = 0;
        in_valid = 1; in_data = d; in_last = l;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic get_out(input string tag, input logic [63:0] ed, input int ec,
                           input int base, input int eadds);
        int t = 0;
        while (!out_valid && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk({tag, "_timeout"}, 64'(t), 64'd0);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_count"}, 64'(out_count), 64'(ec));
        chk({tag, "_adds"}, 64'(n_add - base), 64'(eadds));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic pulse_spur();
        spur_fin = 1; spur_res = 64'hDEADBEEFDEADBEEF;
        @(negedge clk);
        spur_fin = 0;
    endtask

    initial begin
        int base;
        rst_n = 0; in_valid = 0; in_data = 0; in_last = 0;
        out_ready = 0; spur_fin = 0; spur_res = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_add_valid", 64'(add_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_add_a", add_a, 64'h0);
        chk("rst_add_b", add_b, 64'h0);
        rst_n = 1;
        @(negedge clk);

        // 1 + 2 + 3
        base = n_add;
        send(F1, 0); send(F2, 0); send(F3, 1);
        get_out("v123", F6, 3, base, 2);

        // single element passes through unchanged
        base = n_add;
        send(FM35, 1);
        get_out("single", FM35, 1, base, 0);

        // zeros in the stream
        base = n_add;
        send(F2, 0); send(PZ, 0); send(NZ, 0); send(F1, 1);
        get_out("zeros", F3, 4, base, ZADDS);

        // back-pressure on the output
        base = n_add;
        send(F1, 0); send(F2, 0); send(F3, 1);
        begin
            int t = 0;
            while (!out_valid && t < 500) begin @(negedge clk); t++; end
        end
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", out_data, F6);
            chk("bp_count", 64'(out_count), 64'd3);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp_rel_valid", 64'(out_valid), 64'd0);
        chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
        chk("bp_adds", 64'(n_add - base), 64'd2);

        // reset while an add is in flight; stale finish must be ignored
        send(F1, 0); send(F2, 0);
        repeat (3) @(negedge clk);
        chk("mw_pending", 64'(mdl_cnt > 0), 64'd1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("mw_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (12) @(negedge clk);
        chk("mw_stale_out_valid", 64'(out_valid), 64'd0);
        chk("mw_in_ready", 64'(in_ready), 64'd1);
        base = n_add;
        send(F1, 0); send(F1, 1);
        get_out("mw_next", F2, 2, base, 1);

        // spurious finish in IDLE and FETCH
        @(negedge clk);
        pulse_spur();
        chk("spur_idle_out_valid", 64'(out_valid), 64'd0);
        chk("spur_idle_in_ready", 64'(in_ready), 64'd1);
        base = n_add;
        send(F1, 0);
        pulse_spur();
        chk("spur_fetch_out_valid", 64'(out_valid), 64'd0);
        chk("spur_fetch_in_ready", 64'(in_ready), 64'd1);
        send(F2, 1);
        get_out("spur_sum", F3, 2, base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
